// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard, conv-unit occupancy FSM,
// stall/issue generation and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int NREG     = 32,
  parameter int CONV_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dec_valid,
  input  logic [$clog2(NREG)-1:0]   dec_rA,
  input  logic [$clog2(NREG)-1:0]   dec_rB,
  input  logic                      dec_useA,
  input  logic                      dec_useB,
  input  logic                      dec_src_vec,
  input  logic [$clog2(NREG)-1:0]   dec_rD,
  input  logic                      dec_wr,
  input  logic                      dec_dst_vec,
  input  logic                      dec_conv,
  input  logic [2:0]                dec_strd,
  input  logic                      br_flush,
  input  logic                      wb_write,
  input  logic [$clog2(NREG)-1:0]   wb_rD,
  input  logic                      wb_vec,
  output logic                      stall,
  output logic                      issue,
  output logic                      conv_busy,
  output logic [2*NREG-1:0]         pending,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int CONV_CW = $clog2(CONV_LAT + 8);

  typedef enum logic {S_IDLE, S_BUSY} conv_st_t;

  conv_st_t             r_conv_st;
  logic [CONV_CW-1:0]   r_conv_cnt;
  logic [2*NREG-1:0]    r_pending;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic                 w_raw;
  logic                 w_waw;
  logic                 w_sth;
  logic                 w_stall;
  logic                 w_issue;
  logic                 w_conv_busy;
  logic [CONV_CW-1:0]   w_conv_load;
  logic [2*NREG-1:0]    w_set;
  logic [2*NREG-1:0]    w_clr;

  // The scoreboard index {file, reg} maps the vector file onto the upper half.
  assign w_raw = (dec_useA & r_pending[{dec_src_vec, dec_rA}]) |
                 (dec_useB & r_pending[{dec_src_vec, dec_rB}]);
  assign w_waw = dec_wr & r_pending[{dec_dst_vec, dec_rD}];

  assign w_conv_busy = reset & (r_conv_st == S_BUSY);
  assign w_sth       = dec_conv & w_conv_busy;

  assign w_stall = reset & dec_valid & ~br_flush & (w_raw | w_waw | w_sth);
  assign w_issue = reset & dec_valid & ~br_flush & ~w_stall;

  assign w_conv_load = CONV_CW'(CONV_LAT - 1) + CONV_CW'(dec_strd);

  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (wb_write)
      w_clr[{wb_vec, wb_rD}] = 1'b1;
    if (w_issue && dec_wr)
      w_set[{dec_dst_vec, dec_rD}] = 1'b1;
  end

  // Set is applied after clear so a newer writer of the retiring register still pends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Busy lasts exactly the loaded count; the cycle that decrements to zero is the last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_conv_st  <= S_IDLE;
      r_conv_cnt <= '0;
    end else begin
      case (r_conv_st)
        S_IDLE: begin
          if (w_issue && dec_conv) begin
            r_conv_st  <= S_BUSY;
            r_conv_cnt <= w_conv_load;
          end
        end
        S_BUSY: begin
          r_conv_cnt <= r_conv_cnt - CONV_CW'(1);
          if (r_conv_cnt == CONV_CW'(1))
            r_conv_st <= S_IDLE;
        end
        default: begin
          r_conv_st  <= S_IDLE;
          r_conv_cnt <= '0;
        end
      endcase
    end
  end

  assign stall     = w_stall;
  assign issue     = w_issue;
  assign conv_busy = w_conv_busy;
  assign pending   = r_pending;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a scoreboard/occupancy model.
module tb_hazard_ctrl;

  localparam int NREG     = 32;
  localparam int CONV_LAT = 4;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid, dec_useA, dec_useB, dec_src_vec, dec_wr, dec_dst_vec, dec_conv;
  logic [4:0]       dec_rA, dec_rB, dec_rD, wb_rD;
  logic [2:0]       dec_strd;
  logic             br_flush, wb_write, wb_vec;
  logic             stall, issue, conv_busy;
  logic [2*NREG-1:0] pending;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: in-flight writers per file, remaining conv busy cycles, stall count.
  bit mp [2][NREG];
  int m_rem;
  int m_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.NREG(NREG), .CONV_LAT(CONV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rA(dec_rA), .dec_rB(dec_rB),
    .dec_useA(dec_useA), .dec_useB(dec_useB), .dec_src_vec(dec_src_vec),
    .dec_rD(dec_rD), .dec_wr(dec_wr), .dec_dst_vec(dec_dst_vec),
    .dec_conv(dec_conv), .dec_strd(dec_strd), .br_flush(br_flush),
    .wb_write(wb_write), .wb_rD(wb_rD), .wb_vec(wb_vec),
    .stall(stall), .issue(issue), .conv_busy(conv_busy),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return reset && (m_rem > 0);
  endfunction

  function automatic bit m_stall();
    bit hz;
    int sf, df;
    sf = dec_src_vec ? 1 : 0;
    df = dec_dst_vec ? 1 : 0;
    hz = (dec_useA && mp[sf][dec_rA]) || (dec_useB && mp[sf][dec_rB]) ||
         (dec_wr && mp[df][dec_rD]) || (dec_conv && m_busy());
    return reset && dec_valid && !br_flush && hz;
  endfunction

  function automatic bit m_issue();
    return reset && dec_valid && !br_flush && !m_stall();
  endfunction

  function automatic logic [2*NREG-1:0] m_pend();
    logic [2*NREG-1:0] r;
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < NREG; i++)
        r[v*NREG + i] = mp[v][i];
    return r;
  endfunction

  task automatic idle_in();
    reset = 1'b1; dec_valid = 0; dec_useA = 0; dec_useB = 0; dec_src_vec = 0;
    dec_wr = 0; dec_dst_vec = 0; dec_conv = 0; dec_rA = 0; dec_rB = 0; dec_rD = 0;
    dec_strd = 0; br_flush = 0; wb_write = 0; wb_rD = 0; wb_vec = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    check("stall",     stall,     m_stall());
    check("issue",     issue,     m_issue());
    check("conv_busy", conv_busy, m_busy());
    check("pending",   pending,   m_pend());
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic tick();
    bit s, is;
    s  = m_stall();
    is = m_issue();
    @(posedge clk);
    #1;
    if (!reset) begin
      foreach (mp[v, i]) mp[v][i] = 0;
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (wb_write) mp[wb_vec][wb_rD] = 0;
      if (is && dec_wr) mp[dec_dst_vec][dec_rD] = 1;
      if (m_rem > 0) m_rem--;
      if (is && dec_conv) m_rem = CONV_LAT + dec_strd - 1;
      if (s && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b0;
    sample();
    tick();
    idle_in();
  endtask

  initial begin
    int busy_n, st_n;
    bit got;
    foreach (mp[v, i]) mp[v][i] = 0;
    m_rem = 0;
    m_cnt = 0;
    idle_in();
    do_reset();
    sample();
    check("reset_pending", pending, 0);
    check("reset_cnt", stall_cnt, 0);
    tick();

    // RAW on scalar r5, released the cycle after writeback.
    dec_valid = 1; dec_wr = 1; dec_rD = 5; step();
    idle_in(); dec_valid = 1; dec_useA = 1; dec_rA = 5;
    sample(); check("raw_stall", stall, 1); check("pend5_set", pending[5], 1); tick();
    wb_write = 1; wb_rD = 5;
    sample(); check("raw_wb_same_cycle", stall, 1); tick();
    wb_write = 0;
    sample(); check("raw_release", issue, 1); check("pend5_clr", pending[5], 0); tick();

    // Vector v3 pending does not block scalar r3.
    idle_in(); dec_valid = 1; dec_wr = 1; dec_dst_vec = 1; dec_rD = 3; step();
    idle_in(); dec_valid = 1; dec_useB = 1; dec_rB = 3;
    sample(); check("vec_separate", stall, 0); tick();
    dec_src_vec = 1;
    sample(); check("vec_raw", stall, 1); tick();
    idle_in(); wb_write = 1; wb_vec = 1; wb_rD = 3; step();
    idle_in(); step();

    // Conv strd=2, ADD in the shadow, second conv waits for the unit.
    dec_valid = 1; dec_conv = 1; dec_strd = 2; step();
    idle_in(); dec_valid = 1; dec_useA = 1; dec_rA = 1; dec_wr = 1; dec_rD = 2;
    sample(); check("add_free_stall", stall, 0); check("add_free_issue", issue, 1);
    check("add_busy", conv_busy, 1); tick();
    idle_in(); wb_write = 1; wb_rD = 2; dec_valid = 1; dec_conv = 1; dec_strd = 1;
    busy_n = 1; st_n = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      sample();
      wb_write = 0;
      if (conv_busy) busy_n++;
      if (stall) st_n++;
      if (issue) begin
        got = 1;
        check("conv2_issue_idle", conv_busy, 0);
      end
      tick();
    end
    check("conv2_issued", got, 1);
    check("conv2_stall_len", st_n, 4);
    check("conv_busy_len", busy_n, 5);
    idle_in();
    repeat (10) step();

    // Flush suppresses hazard stall and wrong-path scoreboard set.
    dec_valid = 1; dec_wr = 1; dec_rD = 5; step();
    idle_in(); dec_valid = 1; dec_useA = 1; dec_rA = 5; dec_wr = 1; dec_rD = 7; br_flush = 1;
    sample(); check("flush_stall", stall, 0); check("flush_issue", issue, 0); tick();
    idle_in();
    sample(); check("flush_pend7", pending[7], 0); tick();
    wb_write = 1; wb_rD = 5; step();

    // Retire and new write of r9 in the same cycle: set wins.
    idle_in(); dec_valid = 1; dec_wr = 1; dec_rD = 9; wb_write = 1; wb_rD = 9;
    sample(); check("r9_issue", issue, 1); tick();
    idle_in();
    sample(); check("r9_pend", pending[9], 1); tick();
    wb_write = 1; wb_rD = 9; step();
    idle_in(); step();

    // Random traffic on a small register window to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(99) >= 2);
      dec_valid   = ($urandom_range(9) < 8);
      dec_rA      = 5'($urandom_range(3));
      dec_rB      = 5'($urandom_range(3));
      dec_rD      = 5'($urandom_range(3));
      dec_useA    = 1'($urandom_range(1));
      dec_useB    = 1'($urandom_range(1));
      dec_src_vec = 1'($urandom_range(1));
      dec_wr      = 1'($urandom_range(1));
      dec_dst_vec = 1'($urandom_range(1));
      dec_conv    = ($urandom_range(4) == 0);
      dec_strd    = 3'($urandom_range(7));
      br_flush    = ($urandom_range(9) == 0);
      wb_write    = ($urandom_range(9) < 4);
      wb_rD       = 5'($urandom_range(3));
      wb_vec      = 1'($urandom_range(1));
      step();
    end
    do_reset();

    // Long continuous stall saturates the counter; a conv is in flight when reset hits.
    dec_valid = 1; dec_wr = 1; dec_rD = 5; step();
    idle_in(); dec_valid = 1; dec_useA = 1; dec_rA = 5;
    repeat (70000) step();
    sample(); check("cnt_saturated", stall_cnt, 16'hFFFF); tick();
    idle_in(); dec_valid = 1; dec_conv = 1; dec_strd = 7; step();
    idle_in(); reset = 0;
    sample(); check("rst_stall", stall, 0); check("rst_issue", issue, 0);
    check("rst_busy", conv_busy, 0); tick();
    idle_in();
    sample(); check("post_rst_cnt", stall_cnt, 0); check("post_rst_pend", pending, 0);
    check("post_rst_busy", conv_busy, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and resource controller for the 5-stage NPU core (Fetch, Decode, Execute, Memory, WriteBack).
- Keeps a scoreboard of in-flight scalar and vector destination registers.
- Stalls Decode on RAW/WAW hazards and on a busy multi-cycle convolution unit.
- Gates issue into Decode_to_Execute and suppresses issue on branch/jump flush.

Parameters:
NREG, 32, registers per file (scalar and vector files each; index width 5)
CONV_LAT, 4, base occupancy of the conv unit in cycles per conv instruction
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
dec_valid  in  1  Decode holds a valid instruction
dec_rA  in  5  source A index
dec_rB  in  5  source B index
dec_useA  in  1  instruction reads rA
dec_useB  in  1  instruction reads rB
dec_src_vec  in  1  sources come from the vector file (0 = scalar)
dec_rD  in  5  destination index
dec_wr  in  1  instruction writes rD
dec_dst_vec  in  1  destination is in the vector file
dec_conv  in  1  instruction uses the conv unit
dec_strd  in  3  strd_cyc value; extra conv occupancy cycles
br_flush  in  1  b_taken OR jmp this cycle
wb_write  in  1  WriteBack commits a register this cycle
wb_rD  in  5  WriteBack destination index
wb_vec  in  1  WriteBack target is the vector file
stall  out  1  hold PC and Fetch_to_Decode; bubble into Decode_to_Execute
issue  out  1  Decode instruction is accepted into Execute this cycle
conv_busy  out  1  conv unit occupied
pending  out  2*NREG  scoreboard, [NREG-1:0] scalar, [2*NREG-1:NREG] vector
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset==0 at posedge): pending=0, conv FSM=IDLE, conv counter=0, stall_cnt=0.
- Combinational outputs during reset: stall=0, issue=0, conv_busy=0.
- Hazard terms (combinational, from registered state only):
  - raw = (dec_useA & pending[file(dec_src_vec)][dec_rA]) | (dec_useB & pending[file(dec_src_vec)][dec_rB]).
  - waw = dec_wr & pending[file(dec_dst_vec)][dec_rD].
  - sth = dec_conv & conv_busy.
- A same-cycle wb_write to a hazard register does NOT clear the hazard. The register file is written at the edge, so the instruction reissues one cycle later.
- stall = dec_valid & ~br_flush & (raw | waw | sth).
- issue = dec_valid & ~br_flush & ~stall.
- br_flush dominates: stall=0, issue=0, and no scoreboard set that cycle.
- Scoreboard update at posedge:
  - clear bit [wb_vec][wb_rD] if wb_write.
  - set bit [dec_dst_vec][dec_rD] if issue & dec_wr.
  - Same bit set and cleared in one cycle: set wins, because the newer writer still pends.
- Conv FSM:
  - States IDLE and BUSY. conv_busy = (state==BUSY).
  - IDLE -> BUSY on issue & dec_conv. Counter loads CONV_LAT + dec_strd - 1 (range 3..10 at default).
  - BUSY: counter decrements each cycle. At counter==0, return to IDLE.
  - A dec_conv in the last BUSY cycle still stalls; it issues the next cycle.
  - Non-conv instructions issue freely while BUSY.
  - br_flush does not cancel an in-progress conv, because it is older than the branch.
- stall_cnt increments on each cycle with stall=1 and saturates at 2^CNT_W-1.
- Reset asserted mid-operation: all state returns to reset values on that edge. An in-flight conv is abandoned.
- dec_valid=0: no hazard evaluation; stall=0, issue=0.

Test Plan:
- Issue scalar write r5 (dec_wr=1, dec_rD=5). Next cycle an instruction reads rA=5 -> stall=1 until the cycle after wb_write with wb_rD=5, then issue=1. pending[5] reads 1 then 0.
- Vector write v3 pending, then a scalar read of r3 -> no stall (separate files). A vector read of v3 -> stall=1.
- Conv with dec_strd=2 -> conv_busy=1 for exactly 5 cycles. A second conv arriving 1 cycle later stalls 4 cycles and issues on the cycle after conv_busy falls. An ADD in between issues with stall=0.
- Hazard instruction with br_flush=1 -> stall=0, issue=0. A wrong-path write to r7 leaves pending[7]=0.
- Same cycle: wb_write r9 retires while a new instruction issues a write to r9 -> pending[9]=1 afterwards.
- Drive continuous stall for 70000 cycles with CNT_W=16 -> stall_cnt=65535. Then reset=0 for one edge -> stall_cnt=0, pending=0, conv_busy=0.
